// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle ripple adder/subtractor that adds CHUNK bits per
// clock. Operands are captured on accept, chunks are summed LSB-first through
// a carry register, and the result is held with a valid/ready handshake.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_next;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a, r_b, r_s;
  logic             r_c, r_ovf;

  logic [CHUNK-1:0] w_a_chk, w_b_chk;
  logic [CHUNK:0]   w_sum;
  logic             w_cin_msb;
  logic             w_accept;
  logic             w_last;

  // Slice the current chunk and add it with the running carry.
  // The carry into the chunk's top bit is recovered from sum ^ a ^ b at that
  // bit, which works for any CHUNK including 1.
  always_comb begin
    w_a_chk   = r_a[r_idx*CHUNK +: CHUNK];
    w_b_chk   = r_b[r_idx*CHUNK +: CHUNK];
    w_sum     = {1'b0, w_a_chk} + {1'b0, w_b_chk} + {{CHUNK{1'b0}}, r_carry};
    w_cin_msb = w_sum[CHUNK-1] ^ w_a_chk[CHUNK-1] ^ w_b_chk[CHUNK-1];
    w_last    = (r_idx == LAST);
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Operand capture, per-chunk accumulation and final flag generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_c     <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in1;
      r_b     <= sub ? ~in2 : in2;
      r_carry <= sub ? 1'b1 : cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_s[r_idx*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
      r_carry                   <= w_sum[CHUNK];
      if (w_last) begin
        r_idx <= '0;
        r_c   <= w_sum[CHUNK];
        r_ovf <= w_cin_msb ^ w_sum[CHUNK];
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign s   = r_s;
  assign c   = r_c;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder (WIDTH=16, CHUNK=4).
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in1 = '0, in2 = '0;
  logic        cin = 1'b0, sub = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, c, ovf, out_valid;
  logic [15:0] s;

  int nchk  = 0;
  int npass = 0;
  int nfail = 0;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .cin(cin), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .c(c), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid after an accept edge; inputs are scrambled meanwhile
  // so any leak of live inputs into the result shows up.
  task automatic wait_result(input string tag, input logic [15:0] es,
                             input logic ec, input logic eo);
    int cnt = 0;
    while (!out_valid && cnt < 20) begin
      in1 = $urandom; in2 = $urandom; cin = ~cin; sub = ~sub;
      chk({tag, "_busy_rdy"}, in_ready, 0);
      step();
      cnt++;
    end
    chk({tag, "_lat"}, cnt, 4);
    chk({tag, "_s"}, s, es);
    chk({tag, "_c"}, c, ec);
    chk({tag, "_ovf"}, ovf, eo);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb);
    in1 = a; in2 = b; cin = ci; sub = sb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, out_valid, 0);
    chk({tag, "_ir_high"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input logic [15:0] es,
                        input logic ec, input logic eo);
    chk({tag, "_ir_pre"}, in_ready, 1);
    start_op(a, b, ci, sb);
    wait_result(tag, es, ec, eo);
    take(tag);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ir", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_c", c, 0);
    chk("rst_ovf", ovf, 0);
    step();
    rst = 1'b0;
    step();

    run_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_cin",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    run_op("sub_5_7",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    // cin is ignored in subtract mode
    run_op("sub_cin_ign", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("add_zero_cin", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    run_op("add_neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Back-pressure: hold result for 3 cycles while poking inputs.
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_result("bp", 16'h5555, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      in1 = $urandom; in2 = $urandom; in_valid = ~in_valid;
      step();
      chk("bp_s", s, 16'h5555);
      chk("bp_c", c, 0);
      chk("bp_ovf", ovf, 0);
      chk("bp_ov", out_valid, 1);
      chk("bp_ir", in_ready, 0);
    end
    // Present the next op on the take edge: it must not be accepted there.
    in1 = 16'h0003; in2 = 16'h0004; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_take_ov", out_valid, 0);
    chk("bp_take_ir", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_next_acc", in_ready, 0);
    wait_result("bp_next", 16'h0007, 1'b0, 1'b0);
    take("bp_next");

    // Mid-operation reset after the 2nd RUN edge.
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mrst_s", s, 0);
    chk("mrst_c", c, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_ov", out_valid, 0);
    chk("mrst_ir", in_ready, 1);
    step();
    step();
    rst = 1'b0;
    step();
    run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4, SHALL set the bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, with N = WIDTH/CHUNK >= 1.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 in1  input  WIDTH  SHALL carry operand A.
REQ-006 in2  input  WIDTH  SHALL carry operand B.
REQ-007 cin  input  1  SHALL carry the carry-in (add mode only).
REQ-008 sub  input  1  SHALL select the mode: 0 = A+B+cin; 1 = A-B.
REQ-009 in_valid  input  1  SHALL flag that in1/in2/cin/sub are valid.
REQ-010 in_ready  output  1  SHALL flag that the block can accept an operation.
REQ-011 s  output  WIDTH  SHALL carry the result sum.
REQ-012 c  output  1  SHALL carry the result carry-out (in subtract mode, 1 = no borrow).
REQ-013 ovf  output  1  SHALL carry the two's-complement signed overflow flag.
REQ-014 out_valid  output  1  SHALL flag that s/c/ovf hold a completed result.
REQ-015 out_ready  input  1  SHALL flag that the consumer accepts the result.

Function
REQ-016 The block SHALL use FSM states IDLE, RUN and DONE.
REQ-017 In IDLE: in_ready = 1, out_valid = 0.
REQ-018 In RUN and DONE: in_ready = 0.
REQ-019 Accept SHALL occur on a rising edge where in_valid && in_ready.
- Latch A = in1 and B' = sub ? ~in2 : in2.
- Load the carry register with sub ? 1 : cin.
- Clear the chunk index; go to RUN.
REQ-020 Each RUN cycle SHALL add chunk i of A and chunk i of B' plus the carry register.
- Write the CHUNK-bit sum into bits [i*CHUNK +: CHUNK] of the s register.
- Store the chunk carry-out into the carry register.
- Increment i.
REQ-021 On the RUN cycle with i = N-1:
- Set c = final carry-out.
- Set ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
- Go to DONE.
REQ-022 Latency: out_valid SHALL rise exactly N rising edges after the accept edge.
REQ-023 In DONE, out_valid SHALL be 1, and s, c and ovf SHALL be held stable until the result is taken.
REQ-024 On an edge in DONE with out_ready = 1, the block SHALL go to IDLE; out_valid falls and in_ready rises on that same edge.
REQ-025 A new operation SHALL NOT be accepted on the same edge a result is taken (one-cycle IDLE bubble); back-to-back throughput is one op per N+2 cycles.
REQ-026 Inputs in1/in2/cin/sub SHALL be ignored outside the accept edge; changes during RUN SHALL NOT affect the result.
REQ-027 in_valid while in RUN or DONE SHALL have no effect.
REQ-028 out_ready outside DONE SHALL have no effect.
REQ-029 Results SHALL be modulo 2^WIDTH; c is bit WIDTH of the full sum.
REQ-030 For N = 1 (CHUNK = WIDTH), the block SHALL spend exactly one cycle in RUN.

Reset
REQ-031 While rst is high, the block SHALL asynchronously force:
- state = IDLE, chunk index = 0, carry register = 0;
- s = 0, c = 0, ovf = 0;
- out_valid = 0, in_ready = 1.
REQ-032 Reset asserted during RUN or DONE SHALL abort the operation with no output; the first accept after rst deasserts SHALL compute correctly.

Verification (WIDTH = 16, CHUNK = 4)
REQ-033 Add 0xFFFF + 0x0001, cin = 0 -> s = 0x0000, c = 1, ovf = 0; out_valid high 4 edges after accept.
REQ-034 Add 0x7FFF + 0x0001, cin = 0 -> s = 0x8000, c = 0, ovf = 1.
REQ-035 Add 0x1234 + 0x4321, cin = 1 -> s = 0x5556, c = 0, ovf = 0.
REQ-036 Subtract 0x0005 - 0x0007 -> s = 0xFFFE, c = 0, ovf = 0; subtract 0x8000 - 0x0001 -> s = 0x7FFF, c = 1, ovf = 1.
REQ-037 Back-pressure: hold out_ready = 0 for 3 cycles in DONE while toggling in1/in2/in_valid.
- s, c, ovf and out_valid stay stable; in_ready stays 0.
- out_ready = 1 -> IDLE next edge; the next op is accepted one cycle later.
REQ-038 Mid-operation reset: assert rst after the 2nd RUN edge.
- Outputs go to zero immediately; in_ready = 1.
- After release, 0x00FF + 0x0001 -> s = 0x0100, c = 0.
